// File: rtl/sw_fetch.sv
// sw_fetch: raster fetch of one SW x SW search window from frame memory.
// Streams registered pixels and a shift enable toward the PE-array delay lines.
module sw_fetch #(
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 12,
    parameter int FRAME_W = 64,
    parameter int SW      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic              stall,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [DWIDTH-1:0] pix_out,
    output logic              pix_valid,
    output logic              sr_en,
    output logic              busy,
    output logic              done
);

    localparam int CW = (SW > 1) ? $clog2(SW) : 1;
    localparam logic [CW-1:0] LAST = CW'(SW - 1);
    // Jump from the end of one window row to the start of the next frame row.
    localparam logic [AWIDTH-1:0] WRAP_STEP = AWIDTH'(FRAME_W - SW + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nx;
    logic [CW-1:0] row, col;
    logic last_rd;

    assign last_rd = (row == LAST) && (col == LAST);
    assign sr_en   = pix_valid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and control strobes.
    always_comb begin
        state_nx = state;
        mem_rd   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = FETCH;
            end
            FETCH: begin
                busy   = 1'b1;
                mem_rd = ~stall;
                if (!stall && last_rd) state_nx = DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Raster counters and incremental address; everything holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
            row      <= '0;
            col      <= '0;
        end else if (state == IDLE && start) begin
            mem_addr <= base_addr;
            row      <= '0;
            col      <= '0;
        end else if (mem_rd) begin
            if (col == LAST) begin
                col      <= '0;
                row      <= row + 1'b1;
                mem_addr <= mem_addr + WRAP_STEP;
            end else begin
                col      <= col + 1'b1;
                mem_addr <= mem_addr + 1'b1;
            end
        end
    end

    // Pixel output register; data is held whenever no read was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_out   <= '0;
        end else begin
            pix_valid <= mem_rd;
            if (mem_rd) pix_out <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_sw_fetch.sv
// tb_sw_fetch: directed scenario tests for sw_fetch.
// Memory model returns addr[7:0] so every pixel identifies its address.
module tb_sw_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic [11:0] base_addr;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        sr_en;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    int n_reads, n_pix, addr_err, pix_err, hold_err, sren_err;
    int n_busy, n_done, done_cyc, pix_at_stall, reads_after_stall;
    logic [11:0] a_first, a_31, a_32, a_last;
    logic [7:0]  last_pix;
    logic        rst_zero_ok;

    sw_fetch #(
        .DWIDTH (8),
        .AWIDTH (12),
        .FRAME_W(64),
        .SW     (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .stall    (stall),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_rdata(mem_rdata),
        .pix_out  (pix_out),
        .pix_valid(pix_valid),
        .sr_en    (sr_en),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr[7:0];

    function automatic logic [11:0] exp_addr(input logic [11:0] b, input int i);
        return b + 12'((i / 32) * 64 + (i % 32));
    endfunction

    // Drives one window request and gathers statistics cycle by cycle.
    // Cycle 0 is the cycle in which start is presented.
    task automatic run(input logic [11:0] b, input int stall_at, input int stall_len,
                       input int rst_at, input int mid_start, input bit start_in_done,
                       input int max_cyc);
        int cyc;
        int tail;
        logic [11:0] ea;
        n_reads = 0; n_pix = 0; addr_err = 0; pix_err = 0; hold_err = 0;
        sren_err = 0; n_busy = 0; n_done = 0; done_cyc = -1;
        pix_at_stall = -1; reads_after_stall = -1;
        a_first = '0; a_31 = '0; a_32 = '0; a_last = '0;
        rst_zero_ok = 1'b1;
        tail = 0;
        @(negedge clk);
        base_addr = b;
        start = 1'b1;
        stall = 1'b0;
        cyc = 0;
        while (cyc < max_cyc && tail < 6) begin
            if (cyc > 0) begin
                start = (cyc == mid_start) || (start_in_done && done);
                if (cyc == mid_start) base_addr = 12'h300;
            end
            stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            if (cyc == rst_at + 1) rst = 1'b0;
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                if (mem_rd || pix_valid || sr_en || busy || done ||
                    mem_addr != 12'h000 || pix_out != 8'h00)
                    rst_zero_ok = 1'b0;
                last_pix = 8'h00;
            end
            #1;
            if (mem_rd) begin
                ea = exp_addr(b, n_reads);
                if (mem_addr !== ea) addr_err++;
                if (n_reads == 0) a_first = mem_addr;
                if (n_reads == 31) a_31 = mem_addr;
                if (n_reads == 32) a_32 = mem_addr;
                if (n_reads == 1023) a_last = mem_addr;
                n_reads++;
            end
            if (pix_valid) begin
                ea = exp_addr(b, n_pix);
                if (pix_out !== ea[7:0]) pix_err++;
                last_pix = pix_out;
                n_pix++;
            end else if (pix_out !== last_pix) begin
                hold_err++;
            end
            if (sr_en !== pix_valid) sren_err++;
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (cyc == stall_at) pix_at_stall = n_pix;
            if (cyc == stall_at + stall_len - 1) reads_after_stall = n_reads;
            if (n_done > 0) tail++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        stall = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        base_addr = 12'h000;
        repeat (2) @(negedge clk);
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        total++; if (pix_valid !== 1'b0 || sr_en !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b%b exp=00", pix_valid, sr_en); end
        total++; if (mem_addr !== 12'h000) begin bad++; $display("FAIL reset_addr got=%h exp=000", mem_addr); end
        total++; if (pix_out !== 8'h00) begin bad++; $display("FAIL reset_pix got=%h exp=00", pix_out); end
        rst = 1'b0;
        last_pix = 8'h00;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || mem_rd !== 1'b0) begin bad++; $display("FAIL idle_no_start got=%b%b exp=00", busy, mem_rd); end
    endtask

    task automatic test_basic;
        run(12'h100, -100, 0, -100, -1, 1'b0, 2000);
        total++; if (n_reads !== 1024) begin bad++; $display("FAIL basic_reads got=%0d exp=1024", n_reads); end
        total++; if (n_pix !== 1024) begin bad++; $display("FAIL basic_pix got=%0d exp=1024", n_pix); end
        total++; if (addr_err !== 0) begin bad++; $display("FAIL basic_addr_order errors=%0d exp=0", addr_err); end
        total++; if (pix_err !== 0) begin bad++; $display("FAIL basic_pix_data errors=%0d exp=0", pix_err); end
        total++; if (a_first !== 12'h100) begin bad++; $display("FAIL basic_first got=%h exp=100", a_first); end
        total++; if (a_31 !== 12'h11F) begin bad++; $display("FAIL basic_row_end got=%h exp=11F", a_31); end
        total++; if (a_32 !== 12'h140) begin bad++; $display("FAIL basic_row_wrap got=%h exp=140", a_32); end
        total++; if (a_last !== 12'h8DF) begin bad++; $display("FAIL basic_last got=%h exp=8DF", a_last); end
        total++; if (done_cyc !== 1026) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=1026", done_cyc); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
        total++; if (n_busy !== 1025) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=1025", n_busy); end
        total++; if (sren_err !== 0) begin bad++; $display("FAIL basic_sr_en errors=%0d exp=0", sren_err); end
        total++; if (hold_err !== 0) begin bad++; $display("FAIL basic_pix_hold errors=%0d exp=0", hold_err); end
    endtask

    task automatic test_stall;
        // Read 100 issues in cycle 101; stall covers cycles 102..106.
        run(12'h100, 102, 5, -100, -1, 1'b0, 2000);
        total++; if (pix_at_stall !== 101) begin bad++; $display("FAIL stall_inflight_pix got=%0d exp=101", pix_at_stall); end
        total++; if (reads_after_stall !== 101) begin bad++; $display("FAIL stall_no_reads got=%0d exp=101", reads_after_stall); end
        total++; if (n_pix !== 1024) begin bad++; $display("FAIL stall_pix got=%0d exp=1024", n_pix); end
        total++; if (addr_err !== 0 || pix_err !== 0) begin bad++; $display("FAIL stall_data addr_err=%0d pix_err=%0d exp=0", addr_err, pix_err); end
        total++; if (hold_err !== 0) begin bad++; $display("FAIL stall_pix_hold errors=%0d exp=0", hold_err); end
        total++; if (done_cyc !== 1031) begin bad++; $display("FAIL stall_done_cycle got=%0d exp=1031", done_cyc); end
    endtask

    task automatic test_rst_mid;
        // Read 500 would issue in cycle 501; reset lands there instead.
        run(12'h100, -100, 0, 501, -1, 1'b0, 540);
        total++; if (rst_zero_ok !== 1'b1) begin bad++; $display("FAIL rst_outputs_zero got=%b exp=1", rst_zero_ok); end
        total++; if (n_done !== 0) begin bad++; $display("FAIL rst_no_done got=%0d exp=0", n_done); end
        total++; if (n_reads !== 500) begin bad++; $display("FAIL rst_reads got=%0d exp=500", n_reads); end
        total++; if (n_pix !== 499) begin bad++; $display("FAIL rst_pix got=%0d exp=499", n_pix); end
        run(12'h100, -100, 0, -100, -1, 1'b0, 2000);
        total++; if (a_first !== 12'h100) begin bad++; $display("FAIL rst_restart_first got=%h exp=100", a_first); end
        total++; if (n_pix !== 1024 || addr_err !== 0) begin bad++; $display("FAIL rst_restart pix=%0d addr_err=%0d exp=1024/0", n_pix, addr_err); end
        total++; if (done_cyc !== 1026) begin bad++; $display("FAIL rst_restart_done got=%0d exp=1026", done_cyc); end
    endtask

    task automatic test_start_ignored;
        run(12'h100, -100, 0, -100, 300, 1'b1, 2000);
        total++; if (n_reads !== 1024) begin bad++; $display("FAIL ign_reads got=%0d exp=1024", n_reads); end
        total++; if (addr_err !== 0) begin bad++; $display("FAIL ign_addr errors=%0d exp=0", addr_err); end
        total++; if (n_done !== 1 || done_cyc !== 1026) begin bad++; $display("FAIL ign_done count=%0d cycle=%0d exp=1/1026", n_done, done_cyc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_wrap;
        run(12'hFF0, -100, 0, -100, -1, 1'b0, 2000);
        total++; if (a_first !== 12'hFF0) begin bad++; $display("FAIL wrap_first got=%h exp=FF0", a_first); end
        total++; if (a_31 !== 12'h00F) begin bad++; $display("FAIL wrap_row_end got=%h exp=00F", a_31); end
        total++; if (a_32 !== 12'h030) begin bad++; $display("FAIL wrap_row_wrap got=%h exp=030", a_32); end
        total++; if (a_last !== 12'h7CF) begin bad++; $display("FAIL wrap_last got=%h exp=7CF", a_last); end
        total++; if (addr_err !== 0 || pix_err !== 0) begin bad++; $display("FAIL wrap_data addr_err=%0d pix_err=%0d exp=0", addr_err, pix_err); end
        total++; if (n_pix !== 1024 || done_cyc !== 1026) begin bad++; $display("FAIL wrap_count pix=%0d done=%0d exp=1024/1026", n_pix, done_cyc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_rst_mid();
        test_start_ignored();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_fetch.md
SW_FETCH -- requirements
Module: sw_fetch

Interface
REQ-001 Parameter DWIDTH, default 8: pixel width in bits.
REQ-002 Parameter AWIDTH, default 12: frame-memory address width.
REQ-003 Parameter FRAME_W, default 64: frame line pitch in pixels.
REQ-004 Parameter SW, default 32: search-window edge in pixels (block 16 + 2x range 8).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to fetch one search window; sampled only in IDLE.
REQ-008 base_addr  input  AWIDTH  frame address of the window's top-left pixel; captured on accepted start.
REQ-009 stall  input  1  downstream hold; while 1, no new memory read is issued.
REQ-010 mem_addr  output  AWIDTH  frame-memory read address.
REQ-011 mem_rd  output  1  read strobe; the memory returns data exactly one cycle later.
REQ-012 mem_rdata  input  DWIDTH  read data, valid the cycle after mem_rd.
REQ-013 pix_out  output  DWIDTH  registered pixel toward the PE-array shift chains.
REQ-014 pix_valid  output  1  pix_out valid this cycle.
REQ-015 sr_en  output  1  shift enable for the downstream delay lines; identical to pix_valid.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle pulse after the last pixel of the window.

Function
REQ-018 FSM states: IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE->FETCH when start=1; base_addr latched; row and col counters cleared; busy rises the next cycle.
REQ-020 In FETCH: mem_rd = ~stall (combinational on stall); mem_addr = base + row*FRAME_W + col, formed incrementally, no multiplier.
REQ-021 Address step on each issued read: +1 within a row; +(FRAME_W-SW+1) on the col=SW-1 to col=0 wrap; row increments on that wrap.
REQ-022 Stalled cycle: counters and mem_addr hold; mem_rd=0.
REQ-023 Scan order is raster: row 0 col 0..SW-1, then row 1, up to row SW-1; exactly SW*SW reads per window.
REQ-024 FETCH->DRAIN on the cycle the read for row SW-1, col SW-1 issues.
REQ-025 pix_valid is mem_rd registered one cycle; pix_out is mem_rdata registered on that same edge; the pixel appears 1 cycle after its read.
REQ-026 A read issued just before stall asserts still produces pix_valid=1 the next cycle; stall never suppresses in-flight data.
REQ-027 DRAIN lasts one cycle while the final pixel is presented; DRAIN->DONE.
REQ-028 DONE: done=1, busy=0 for one cycle; DONE->IDLE.
REQ-029 start while not IDLE is ignored; start in the DONE cycle is ignored.
REQ-030 Address arithmetic wraps modulo 2^AWIDTH; no range checking.
REQ-031 pix_out holds its last value when pix_valid=0.

Reset
REQ-032 rst=1 forces IDLE immediately, without waiting for clk.
REQ-033 While rst=1: mem_rd, pix_valid, sr_en, busy, done = 0; mem_addr, pix_out, counters = 0.
REQ-034 rst mid-window aborts: no done pulse, no further pix_valid; the next start restarts from row 0 col 0.

Verification
REQ-035 base_addr=0x100, start, stall=0 -> 1024 reads; first mem_addr 0x100, addr 0x11F then 0x140; last addr 0x100+31*64+31=0x8DF; 1024 pix_valid; done 1026 cycles after start.
REQ-036 Memory model data=addr[7:0] -> pix_out sequence matches the raster order of REQ-023 byte for byte.
REQ-037 stall=1 for 5 cycles at read 100 -> read 100 pixel still delivered, no reads for 5 cycles, resumes at the held address, total still 1024 pixels.
REQ-038 rst pulse at read 500 -> all outputs 0 within the reset cycle, no done; restart yields the full 1024 pixels from base.
REQ-039 start pulsed during FETCH and in the DONE cycle -> ignored; exactly one window fetched.
REQ-040 base_addr=0xFF0 (AWIDTH=12) -> addresses wrap through 0x000; pixel count and done timing unchanged.
